// File: rtl/add_h_border.sv
// add_h_border: multi-flux horizontal border insertion.
// Each S x S block of pels arriving on a flux is widened to S rows of
// (PAD_L + S + PAD_R) words.  The first pel of a row is repeated PAD_L extra
// times on the left and the last pel is repeated PAD_R extra times on the right.
// Every flux keeps its own context, and one word moves per cycle for the
// lowest-index flux that can make progress.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   write_port_out_pel_*      padded pel FIFO: full in, write/din out ({tag, pel})
//   read_port_in_pel_*        raw pel FIFO (FWFT): empty[FLUX] in, read[FLUX] out, dout in
//   read_port_ext_size_*      block-size FIFO (FWFT): empty[FLUX] in, read[FLUX] out, dout in
module add_h_border #(
  parameter int FLUX  = 2,
  parameter int PAD_L = 3,
  parameter int PAD_R = 4,
  localparam int TAG_WIDTH         = (FLUX > 1) ? $clog2(FLUX) : 1,
  localparam int DATA_WIDTH_IN_OUT = 18,
  localparam int DATA_WIDTH_EXT    = 7
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   write_port_out_pel_full,
  output logic                                   write_port_out_pel_write,
  output logic [DATA_WIDTH_IN_OUT+TAG_WIDTH-1:0] write_port_out_pel_din,
  input  logic [FLUX-1:0]                        read_port_in_pel_empty,
  output logic [FLUX-1:0]                        read_port_in_pel_read,
  input  logic [DATA_WIDTH_IN_OUT+TAG_WIDTH-1:0] read_port_in_pel_dout,
  input  logic [FLUX-1:0]                        read_port_ext_size_empty,
  output logic [FLUX-1:0]                        read_port_ext_size_read,
  input  logic [DATA_WIDTH_EXT+TAG_WIDTH-1:0]    read_port_ext_size_dout
);

  localparam int CW = DATA_WIDTH_EXT;

  typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_BODY, ST_RIGHT} state_t;

  state_t                       state_r    [FLUX];
  logic [CW-1:0]                cnt_h_r    [FLUX];
  logic [CW-1:0]                cnt_v_r    [FLUX];
  logic [CW-1:0]                size_r     [FLUX];
  logic [DATA_WIDTH_IN_OUT-1:0] edge_pel_r [FLUX];

  logic [FLUX-1:0]              elig_s;
  logic                         sel_valid_s;
  logic [TAG_WIDTH-1:0]         sel_tag_s;
  state_t                       sel_state_s;
  logic [CW-1:0]                sel_cnt_h_s;
  logic [CW-1:0]                sel_cnt_v_s;
  logic [CW-1:0]                sel_size_s;
  logic [DATA_WIDTH_IN_OUT-1:0] sel_edge_s;
  logic [DATA_WIDTH_IN_OUT-1:0] in_pel_s;
  logic [CW-1:0]                ext_size_s;

  assign in_pel_s   = read_port_in_pel_dout[DATA_WIDTH_IN_OUT-1:0];
  assign ext_size_s = read_port_ext_size_dout[DATA_WIDTH_EXT-1:0];

  // Per-flux eligibility: can this flux make progress this cycle.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < FLUX; i++) begin
      case (state_r[i])
        ST_IDLE:  elig_s[i] = !read_port_ext_size_empty[i];
        ST_LEFT: begin
          if (cnt_h_r[i] == {CW{1'b0}}) begin
            elig_s[i] = !read_port_in_pel_empty[i] && !write_port_out_pel_full;
          end else begin
            elig_s[i] = !write_port_out_pel_full;
          end
        end
        ST_BODY:  elig_s[i] = !read_port_in_pel_empty[i] && !write_port_out_pel_full;
        ST_RIGHT: elig_s[i] = !write_port_out_pel_full;
        default:  elig_s[i] = 1'b0;
      endcase
    end
  end

  // Fixed priority: the lowest eligible flux index wins; reset blocks all action.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_tag_s   = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (elig_s[i] && !rst) begin
        sel_valid_s = 1'b1;
        sel_tag_s   = TAG_WIDTH'(i);
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Context of the selected flux.
  always_comb begin
    sel_state_s = state_r[sel_tag_s];
    sel_cnt_h_s = cnt_h_r[sel_tag_s];
    sel_cnt_v_s = cnt_v_r[sel_tag_s];
    sel_size_s  = size_r[sel_tag_s];
    sel_edge_s  = edge_pel_r[sel_tag_s];
  end

  // FIFO handshakes for the selected flux. Kept apart from din so that the
  // read strobes never depend on the read data.
  always_comb begin
    read_port_in_pel_read    = '0;
    read_port_ext_size_read  = '0;
    write_port_out_pel_write = 1'b0;
    if (sel_valid_s) begin
      case (sel_state_s)
        ST_IDLE:  read_port_ext_size_read[sel_tag_s] = 1'b1;
        ST_LEFT: begin
          write_port_out_pel_write = 1'b1;
          if (sel_cnt_h_s == {CW{1'b0}}) begin
            read_port_in_pel_read[sel_tag_s] = 1'b1;
          end else begin
            read_port_in_pel_read[sel_tag_s] = 1'b0;
          end
        end
        ST_BODY: begin
          write_port_out_pel_write         = 1'b1;
          read_port_in_pel_read[sel_tag_s] = 1'b1;
        end
        ST_RIGHT: write_port_out_pel_write = 1'b1;
        default:  write_port_out_pel_write = 1'b0;
      endcase
    end else begin
      write_port_out_pel_write = 1'b0;
    end
  end

  // Output word: a fresh pel when one is being consumed, otherwise the held edge.
  always_comb begin
    if ((sel_state_s == ST_BODY) ||
        ((sel_state_s == ST_LEFT) && (sel_cnt_h_s == {CW{1'b0}}))) begin
      write_port_out_pel_din = {sel_tag_s, in_pel_s};
    end else begin
      write_port_out_pel_din = {sel_tag_s, sel_edge_s};
    end
  end

  // Context update for the selected flux; every other context holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        state_r[i]    <= ST_IDLE;
        cnt_h_r[i]    <= {CW{1'b0}};
        cnt_v_r[i]    <= {CW{1'b0}};
        size_r[i]     <= {CW{1'b0}};
        edge_pel_r[i] <= {DATA_WIDTH_IN_OUT{1'b0}};
      end
    end else if (sel_valid_s) begin
      case (sel_state_s)
        ST_IDLE: begin
          size_r[sel_tag_s]  <= ext_size_s;
          cnt_h_r[sel_tag_s] <= {CW{1'b0}};
          cnt_v_r[sel_tag_s] <= {CW{1'b0}};
          // A zero-size token is consumed without producing any output.
          if (ext_size_s == {CW{1'b0}}) begin
            state_r[sel_tag_s] <= ST_IDLE;
          end else begin
            state_r[sel_tag_s] <= ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (sel_cnt_h_s == {CW{1'b0}}) begin
            edge_pel_r[sel_tag_s] <= in_pel_s;
            cnt_h_r[sel_tag_s]    <= 7'd1;
          end else if (sel_cnt_h_s == CW'(PAD_L)) begin
            // The first pel of the row was already emitted, so BODY starts at 1.
            if (sel_size_s == 7'd1) begin
              cnt_h_r[sel_tag_s] <= 7'd0;
              state_r[sel_tag_s] <= ST_RIGHT;
            end else begin
              cnt_h_r[sel_tag_s] <= 7'd1;
              state_r[sel_tag_s] <= ST_BODY;
            end
          end else begin
            cnt_h_r[sel_tag_s] <= sel_cnt_h_s + 7'd1;
          end
        end
        ST_BODY: begin
          edge_pel_r[sel_tag_s] <= in_pel_s;
          if (sel_cnt_h_s == (sel_size_s - 7'd1)) begin
            cnt_h_r[sel_tag_s] <= 7'd0;
            state_r[sel_tag_s] <= ST_RIGHT;
          end else begin
            cnt_h_r[sel_tag_s] <= sel_cnt_h_s + 7'd1;
          end
        end
        ST_RIGHT: begin
          if (sel_cnt_h_s == CW'(PAD_R - 1)) begin
            cnt_h_r[sel_tag_s] <= 7'd0;
            if (sel_cnt_v_s == (sel_size_s - 7'd1)) begin
              cnt_v_r[sel_tag_s] <= 7'd0;
              state_r[sel_tag_s] <= ST_IDLE;
            end else begin
              cnt_v_r[sel_tag_s] <= sel_cnt_v_s + 7'd1;
              state_r[sel_tag_s] <= ST_LEFT;
            end
          end else begin
            cnt_h_r[sel_tag_s] <= sel_cnt_h_s + 7'd1;
          end
        end
        default: state_r[sel_tag_s] <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_add_h_border.sv
// Directed self-checking bench for add_h_border (FLUX=2, PAD_L=3, PAD_R=4).
// Two per-flux FWFT FIFOs (pels and sizes) are modelled with arrays. The
// padded output is split into one queue per flux tag and compared against
// hand-expanded golden rows.
module tb_add_h_border;

  typedef logic [18:0] word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic        write;
  word_t       din;
  logic [1:0]  in_empty;
  logic [1:0]  in_read;
  word_t       in_dout;
  logic [1:0]  ext_empty;
  logic [1:0]  ext_read;
  logic [7:0]  ext_dout;

  logic [17:0] pel_mem [2][64];
  logic [6:0]  sz_mem  [2][16];
  logic [5:0]  pel_wr  [2];
  logic [5:0]  pel_rd  [2];
  logic [3:0]  sz_wr   [2];
  logic [3:0]  sz_rd   [2];
  logic        pel_block [2];

  word_t out0_q[$];
  word_t out1_q[$];
  word_t exp0_q[$];
  word_t exp1_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last0    = -1;
  int first1   = -1;
  int full_viol = 0;
  int n0;
  logic       s_write;
  logic [1:0] s_in_read;
  logic [1:0] s_ext_read;

  always #5 clk = ~clk;

  add_h_border #(.FLUX(2), .PAD_L(3), .PAD_R(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .write_port_out_pel_full  (full),
    .write_port_out_pel_write (write),
    .write_port_out_pel_din   (din),
    .read_port_in_pel_empty   (in_empty),
    .read_port_in_pel_read    (in_read),
    .read_port_in_pel_dout    (in_dout),
    .read_port_ext_size_empty (ext_empty),
    .read_port_ext_size_read  (ext_read),
    .read_port_ext_size_dout  (ext_dout)
  );

  // FIFO model status flags.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      in_empty[f]  = pel_block[f] || (pel_rd[f] == pel_wr[f]);
      ext_empty[f] = (sz_rd[f] == sz_wr[f]);
    end
  end

  // FWFT heads, muxed by which flux is being read.
  always_comb begin
    if (in_read[1]) in_dout = {1'b1, pel_mem[1][pel_rd[1]]};
    else            in_dout = {1'b0, pel_mem[0][pel_rd[0]]};
    if (ext_read[1]) ext_dout = {1'b1, sz_mem[1][sz_rd[1]]};
    else             ext_dout = {1'b0, sz_mem[0][sz_rd[0]]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, pop FIFOs just after posedge.
  task automatic step();
    @(negedge clk);
    s_write    = write;
    s_in_read  = in_read;
    s_ext_read = ext_read;
    if (write && full) full_viol++;
    if (write) begin
      if (din[18]) begin
        out1_q.push_back(din);
        if (first1 < 0) first1 = cyc;
      end else begin
        out0_q.push_back(din);
        last0 = cyc;
      end
    end
    @(posedge clk);
    #1;
    for (int f = 0; f < 2; f++) begin
      if (s_in_read[f])  pel_rd[f] = pel_rd[f] + 6'd1;
      if (s_ext_read[f]) sz_rd[f]  = sz_rd[f] + 4'd1;
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int target, input int bound);
    int k;
    k = 0;
    while ((out0_q.size() + out1_q.size() < target) && (k < bound)) begin
      step();
      k++;
    end
  endtask

  task automatic clear_fifos();
    for (int f = 0; f < 2; f++) begin
      pel_wr[f] = 6'd0; pel_rd[f] = 6'd0;
      sz_wr[f]  = 4'd0; sz_rd[f]  = 4'd0;
      pel_block[f] = 1'b0;
    end
  endtask

  task automatic clear_queues();
    out0_q.delete(); out1_q.delete(); exp0_q.delete(); exp1_q.delete();
    last0 = -1; first1 = -1; full_viol = 0;
  endtask

  task automatic push_size(input int f, input logic [6:0] s);
    sz_mem[f][sz_wr[f]] = s;
    sz_wr[f] = sz_wr[f] + 4'd1;
  endtask

  task automatic push_pel(input int f, input logic [17:0] p);
    pel_mem[f][pel_wr[f]] = p;
    pel_wr[f] = pel_wr[f] + 6'd1;
  endtask

  task automatic exp_rep(input logic t, input logic [17:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (t) exp1_q.push_back({1'b1, v});
      else   exp0_q.push_back({1'b0, v});
    end
  endtask

  // Golden row for S=4 with 3 left / 4 right pads.
  task automatic exp_row4(input logic t, input logic [17:0] a, input logic [17:0] b,
                          input logic [17:0] c, input logic [17:0] d);
    exp_rep(t, a, 4); exp_rep(t, b, 1); exp_rep(t, c, 1); exp_rep(t, d, 5);
  endtask

  // Golden row for S=2.
  task automatic exp_row2(input logic t, input logic [17:0] a, input logic [17:0] b);
    exp_rep(t, a, 4); exp_rep(t, b, 5);
  endtask

  // S=4 block with pels base+10*row+col on flux f, plus its golden output.
  task automatic load_block4(input int f, input logic [17:0] base);
    push_size(f, 7'd4);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) push_pel(f, base + 18'(10 * r + c));
      exp_row4(f[0], base + 18'(10 * r), base + 18'(10 * r + 1),
               base + 18'(10 * r + 2), base + 18'(10 * r + 3));
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " count0"}, out0_q.size(), exp0_q.size());
    for (int i = 0; i < out0_q.size() && i < exp0_q.size(); i++)
      chk($sformatf("%s flux0 word%0d", tag, i), 32'(out0_q[i]), 32'(exp0_q[i]));
    chk({tag, " count1"}, out1_q.size(), exp1_q.size());
    for (int i = 0; i < out1_q.size() && i < exp1_q.size(); i++)
      chk($sformatf("%s flux1 word%0d", tag, i), 32'(out1_q[i]), 32'(exp1_q[i]));
  endtask

  initial begin
    rst  = 1'b1;
    full = 1'b0;
    clear_fifos();
    clear_queues();

    // Reset: no handshakes while rst is high, none after with empty FIFOs.
    push_size(0, 7'd4);
    steps(2);
    chk("reset write", 32'(s_write), 32'd0);
    chk("reset in_read", 32'(s_in_read), 32'd0);
    chk("reset ext_read", 32'(s_ext_read), 32'd0);
    clear_fifos();
    rst = 1'b0;
    step();
    chk("idle empty write", 32'(s_write), 32'd0);

    // Flux0 S=4: first row 10,10,10,10,11,12,13,13,13,13,13.
    clear_queues();
    push_size(0, 7'd4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) push_pel(0, 18'(10 * (r + 1) + c));
    exp_rep(1'b0, 18'd10, 4); exp_rep(1'b0, 18'd11, 1);
    exp_rep(1'b0, 18'd12, 1); exp_rep(1'b0, 18'd13, 5);
    exp_row4(1'b0, 18'd20, 18'd21, 18'd22, 18'd23);
    exp_row4(1'b0, 18'd30, 18'd31, 18'd32, 18'd33);
    exp_row4(1'b0, 18'd40, 18'd41, 18'd42, 18'd43);
    steps(45);
    chk("s4 words after 45 cycles", out0_q.size(), 44);
    step();
    chk("s4 done write", 32'(s_write), 32'd0);
    chk("s4 done ext_read", 32'(s_ext_read), 32'd0);
    chk_outputs("s4");

    // S=1, pel 7: 8 words of 7.
    clear_fifos(); clear_queues();
    push_size(0, 7'd1);
    push_pel(0, 18'd7);
    exp_rep(1'b0, 18'd7, 8);
    steps(9);
    step();
    chk("s1 done write", 32'(s_write), 32'd0);
    chk_outputs("s1");

    // Both fluxes S=2: flux0 completes before any flux1 word.
    clear_fifos(); clear_queues();
    push_size(0, 7'd2);
    push_size(1, 7'd2);
    push_pel(0, 18'd1);  push_pel(0, 18'd2);  push_pel(0, 18'd3);  push_pel(0, 18'd4);
    push_pel(1, 18'd51); push_pel(1, 18'd52); push_pel(1, 18'd53); push_pel(1, 18'd54);
    exp_row2(1'b0, 18'd1, 18'd2);   exp_row2(1'b0, 18'd3, 18'd4);
    exp_row2(1'b1, 18'd51, 18'd52); exp_row2(1'b1, 18'd53, 18'd54);
    steps(38);
    chk("dual flux1 after flux0", 32'(first1 > last0), 32'd1);
    chk("dual flux1 start cycle", 32'(first1 - last0), 32'd2);
    chk_outputs("dual");

    // full toggling every other cycle: no lost or duplicated words.
    clear_fifos(); clear_queues();
    load_block4(0, 18'd100);
    for (int k = 0; k < 200 && (out0_q.size() < 44); k++) begin
      full = cyc[0];
      step();
    end
    full = 1'b0;
    chk("full toggle writes while full", full_viol, 0);
    chk_outputs("full toggle");

    // in_pel empty for 5 cycles mid-BODY.
    clear_fifos(); clear_queues();
    load_block4(0, 18'd200);
    steps(6);
    pel_block[0] = 1'b1;
    n0 = out0_q.size();
    steps(5);
    chk("stall words before", n0, 5);
    chk("stall writes during", out0_q.size() - n0, 0);
    pel_block[0] = 1'b0;
    run_until(44, 100);
    chk_outputs("stall");

    // rst during row 2, then a fresh S=2 block.
    clear_fifos(); clear_queues();
    load_block4(0, 18'd300);
    steps(26);
    chk("rst words before", out0_q.size(), 25);
    rst = 1'b1;
    clear_fifos();
    step();
    chk("rst high write", 32'(s_write), 32'd0);
    chk("rst high reads", 32'({s_in_read, s_ext_read}), 32'd0);
    rst = 1'b0;
    step();
    chk("post rst write", 32'(s_write), 32'd0);
    chk("post rst reads", 32'({s_in_read, s_ext_read}), 32'd0);
    clear_queues();
    push_size(0, 7'd2);
    push_pel(0, 18'd5); push_pel(0, 18'd6); push_pel(0, 18'd7); push_pel(0, 18'd8);
    exp_row2(1'b0, 18'd5, 18'd6);
    exp_row2(1'b0, 18'd7, 18'd8);
    steps(19);
    chk_outputs("post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
